// File: rtl/spi_reg_master_pkg.sv
// Shared types and helpers for the SPI register-access master.
// Defines the sequencer states and the MFRC522 address-byte format.
package spi_reg_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ADDR,
        ST_DATA,
        ST_HOLD,
        ST_GAP,
        ST_DONE
    } state_e;

    // Byte clocked out on the final byte of a continuous read.
    localparam logic [7:0] READ_FILL = 8'h00;

    function automatic logic [7:0] addr_byte(input logic rw, input logic [5:0] reg_addr);
        return {rw, reg_addr, 1'b0};
    endfunction

endpackage

// File: rtl/spi_reg_master_byte_shift.sv
// One-byte Mode 0 shifter: divides clk into SCK half-periods, drives mosi MSB first
// and samples miso on each SCK rise. A load on the final falling edge chains bytes seamlessly.
module spi_byte_shift #(
    parameter int CLK_DIV = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       long_lead,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       byte_end,
    output logic [7:0] rx_byte
);

    localparam int CW = $clog2(2 * CLK_DIV);

    logic          active_q, active_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    rx_q, rx_d;

    always_comb begin
        active_d = active_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        rx_d     = rx_q;
        byte_end = active_q && sck_q && (cnt_q == '0) && (bit_q == 3'd7);

        if (active_q) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else if (!sck_q) begin
                sck_d = 1'b1;
                rx_d  = {rx_q[6:0], miso};
                cnt_d = CW'(CLK_DIV - 1);
            end else begin
                sck_d  = 1'b0;
                cnt_d  = CW'(CLK_DIV - 1);
                bit_d  = bit_q + 3'd1;
                sh_d   = {sh_q[6:0], 1'b0};
                mosi_d = sh_q[6];
                if (bit_q == 3'd7) begin
                    active_d = 1'b0;
                    mosi_d   = 1'b0;
                end
            end
        end

        // The first byte of a frame also covers the chip-select setup time.
        if (load) begin
            active_d = 1'b1;
            sck_d    = 1'b0;
            bit_d    = 3'd0;
            sh_d     = tx_byte;
            mosi_d   = tx_byte[7];
            cnt_d    = long_lead ? CW'(2 * CLK_DIV - 1) : CW'(CLK_DIV - 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            sh_q     <= 8'h00;
            rx_q     <= 8'h00;
        end else begin
            active_q <= active_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            rx_q     <= rx_d;
        end
    end

    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign rx_byte = rx_q;

endmodule

// File: rtl/spi_reg_master.sv
// SPI Mode 0 register-access master: address byte then num_bytes data bytes under one cs_n.
// state | meaning: IDLE wait en; SETUP cs_n low lead; ADDR address byte; DATA data bytes;
// HOLD cs_n low tail; GAP cs_n high spacing; DONE one-cycle done pulse.
module spi_reg_master
    import spi_reg_master_pkg::*;
#(
    parameter int CLK_DIV = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] data_in,
    input  logic [7:0] num_bytes,
    output logic       cs_n,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int TW = $clog2(2 * CLK_DIV);

    state_e        state_q, state_d;
    logic          rw_q, rw_d;
    logic [5:0]    addr_q, addr_d;
    logic [7:0]    bytes_q, bytes_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          cs_n_q, cs_n_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [7:0]    dout_q, dout_d;

    logic          load;
    logic          long_lead;
    logic [7:0]    tx_byte;
    logic          byte_end;
    logic [7:0]    rx_byte;
    logic          addr_unused;

    assign addr_unused = addr[6];

    spi_byte_shift #(
        .CLK_DIV(CLK_DIV)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .long_lead(long_lead),
        .tx_byte  (tx_byte),
        .miso     (miso),
        .sck      (sck),
        .mosi     (mosi),
        .byte_end (byte_end),
        .rx_byte  (rx_byte)
    );

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        bytes_d   = bytes_q;
        tmr_d     = tmr_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        dout_d    = dout_q;
        load      = 1'b0;
        long_lead = 1'b0;
        tx_byte   = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    if (num_bytes == 8'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        rw_d      = rw;
                        addr_d    = addr[5:0];
                        bytes_d   = num_bytes;
                        cs_n_d    = 1'b0;
                        busy_d    = 1'b1;
                        tmr_d     = TW'(CLK_DIV - 1);
                        state_d   = ST_SETUP;
                        load      = 1'b1;
                        long_lead = 1'b1;
                        tx_byte   = addr_byte(rw, addr[5:0]);
                    end
                end
            end
            ST_SETUP: begin
                if (tmr_q == '0) state_d = ST_ADDR;
                else             tmr_d   = tmr_q - TW'(1);
            end
            ST_ADDR: begin
                if (byte_end) begin
                    state_d = ST_DATA;
                    load    = 1'b1;
                    tx_byte = !rw_q ? data_in :
                              (bytes_q == 8'd1) ? READ_FILL : addr_byte(rw_q, addr_q);
                end
            end
            ST_DATA: begin
                if (byte_end) begin
                    bytes_d = bytes_q - 8'd1;
                    if (rw_q) dout_d = rx_byte;
                    if (bytes_q == 8'd1) begin
                        state_d = ST_HOLD;
                        tmr_d   = TW'(CLK_DIV - 1);
                    end else begin
                        // Continuous read repeats the address until the final byte.
                        load    = 1'b1;
                        tx_byte = !rw_q ? data_in :
                                  (bytes_q == 8'd2) ? READ_FILL : addr_byte(rw_q, addr_q);
                    end
                end
            end
            ST_HOLD: begin
                if (tmr_q == '0) begin
                    cs_n_d  = 1'b1;
                    tmr_d   = TW'(2 * CLK_DIV - 1);
                    state_d = ST_GAP;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            ST_GAP: begin
                if (tmr_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rw_q    <= 1'b0;
            addr_q  <= 6'd0;
            bytes_q <= 8'd0;
            tmr_q   <= '0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            bytes_q <= bytes_d;
            tmr_q   <= tmr_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            dout_q  <= dout_d;
        end
    end

    assign cs_n     = cs_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign data_out = dout_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master: bus monitor, MISO slave model and hand-computed vectors.
module tb_spi_reg_master;

    localparam int CD = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data_in;
    logic [7:0] num_bytes;
    logic       cs_n;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic       error;

    spi_reg_master #(
        .CLK_DIV(CD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rw       (rw),
        .addr     (addr),
        .data_in  (data_in),
        .num_bytes(num_bytes),
        .cs_n     (cs_n),
        .sck      (sck),
        .mosi     (mosi),
        .miso     (miso),
        .data_out (data_out),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial forever #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Monitor state, written only by the monitor process.
    int         tot_rises = 0;
    int         done_cnt  = 0;
    int         prot_err  = 0;
    int         cs_falls  = 0;
    int         last_gap  = 0;
    logic [7:0] mosi_seen [$];
    logic [7:0] slave_bytes [4];

    initial begin
        int   k;
        int   falls;
        int   bits;
        int   hi_run;
        logic [7:0] sh;
        logic cs_n_p, sck_p, mosi_p, rst_p;
        falls = 0; bits = 0; hi_run = 0; sh = 8'h00;
        cs_n_p = 1'b1; sck_p = 1'b0; mosi_p = 1'b0; rst_p = 1'b1;
        miso = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || rst_p) begin
                if (rst) miso = 1'b0;
            end else begin
                if (cs_n != cs_n_p) begin
                    if (sck || sck_p) prot_err++;
                    if (!cs_n) begin
                        cs_falls++;
                        last_gap = hi_run;
                        falls = 0;
                        bits  = 0;
                        miso  = 1'b0;
                    end else if (bits % 8 != 0) begin
                        prot_err++;
                    end
                end
                if (!cs_n && !busy) prot_err++;
                if (sck && !sck_p) begin
                    if (cs_n) prot_err++;
                    if (mosi != mosi_p) prot_err++;
                    tot_rises++;
                    bits++;
                    sh = {sh[6:0], mosi};
                    if (bits % 8 == 0) mosi_seen.push_back(sh);
                end
                if (!sck && sck_p && !cs_n) begin
                    falls++;
                    if (falls >= 8) begin
                        k = falls - 8;
                        if (k / 8 < 4) miso = slave_bytes[k / 8][7 - (k % 8)];
                        else           miso = 1'b0;
                    end
                end
                if (done) done_cnt++;
            end
            hi_run = cs_n ? hi_run + 1 : 0;
            cs_n_p = cs_n;
            sck_p  = sck;
            mosi_p = mosi;
            rst_p  = rst;
        end
    end

    task automatic run_txn(input string tag, input logic r, input logic [6:0] a,
                           input logic [7:0] n, input logic [7:0] wd, input int nexp,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                           input logic [7:0] exp_dout, input bit poke, input int tail);
        int r0, d0, q0, p0, f0;
        bit seen;
        logic [7:0] ev [3];
        ev = '{e0, e1, e2};
        r0 = tot_rises; d0 = done_cnt; q0 = mosi_seen.size(); p0 = prot_err; f0 = cs_falls;
        @(negedge clk);
        en = 1'b1; rw = r; addr = a; num_bytes = n; data_in = wd;
        @(negedge clk);
        en = 1'b0;
        if (n == 8'd0) begin
            chk({tag, "_done"}, done, 1);
            chk({tag, "_error"}, error, 1);
            chk({tag, "_busy"}, busy, 0);
        end else begin
            chk({tag, "_busy_start"}, busy, 1);
            seen = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                en = poke && (i == 40);
                if (done) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            en = 1'b0;
            chk({tag, "_done_seen"}, seen, 1);
            chk({tag, "_error"}, error, 0);
            chk({tag, "_busy_at_done"}, busy, 0);
            if (r) chk({tag, "_data_out"}, data_out, exp_dout);
        end
        repeat (tail) @(negedge clk);
        chk({tag, "_done_count"}, done_cnt - d0, 1);
        chk({tag, "_sck_rises"}, tot_rises - r0, (n == 8'd0) ? 0 : 8 * (int'(n) + 1));
        chk({tag, "_cs_falls"}, cs_falls - f0, (n == 8'd0) ? 0 : 1);
        chk({tag, "_protocol"}, prot_err - p0, 0);
        chk({tag, "_mosi_bytes"}, mosi_seen.size() - q0, nexp);
        for (int j = 0; j < nexp && q0 + j < mosi_seen.size(); j++)
            chk($sformatf("%s_mosi%0d", tag, j), mosi_seen[q0 + j], ev[j]);
    endtask

    initial begin
        int d0;
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        rst = 1'b1; en = 1'b0; rw = 1'b0; addr = 7'h00; data_in = 8'h00; num_bytes = 8'h00;
        slave_bytes = '{8'h00, 8'h00, 8'h00, 8'h00};
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sck", sck, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);

        run_txn("wr37", 1'b0, 7'h37, 8'd1, 8'hAA, 2, 8'h6E, 8'hAA, 8'h00, 8'h00, 1'b0, 20);

        slave_bytes = '{8'h91, 8'h00, 8'h00, 8'h00};
        run_txn("rd37", 1'b1, 7'h37, 8'd1, 8'h00, 2, 8'hEE, 8'h00, 8'h00, 8'h91, 1'b0, 20);

        slave_bytes = '{8'h91, 8'h00, 8'h00, 8'h00};
        run_txn("b2b_wr", 1'b0, 7'h01, 8'd1, 8'h55, 2, 8'h02, 8'h55, 8'h00, 8'h00, 1'b0, 1);
        run_txn("b2b_rd", 1'b1, 7'h37, 8'd1, 8'h00, 2, 8'hEE, 8'h00, 8'h00, 8'h91, 1'b0, 20);
        chk("b2b_gap_ge_2div", last_gap >= 2 * CD, 1);

        slave_bytes = '{8'h12, 8'h34, 8'h00, 8'h00};
        run_txn("rd2", 1'b1, 7'h37, 8'd2, 8'h00, 3, 8'hEE, 8'hEE, 8'h00, 8'h34, 1'b0, 20);

        run_txn("zero", 1'b0, 7'h10, 8'd0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 40);

        // addr[6] set must not reach the wire; en mid-transaction must be dropped.
        run_txn("poke", 1'b0, 7'h77, 8'd1, 8'hC3, 2, 8'h6E, 8'hC3, 8'h00, 8'h00, 1'b1, 400);

        slave_bytes = '{8'h12, 8'h34, 8'h00, 8'h00};
        d0 = done_cnt;
        @(negedge clk);
        en = 1'b1; rw = 1'b1; addr = 7'h37; num_bytes = 8'd2;
        @(negedge clk);
        en = 1'b0;
        repeat (120) @(negedge clk);
        chk("rst_mid_busy_before", busy, 1);
        chk("rst_mid_cs_before", cs_n, 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_cs_n", cs_n, 1);
        chk("rst_mid_sck", sck, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_data_out", data_out, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        chk("rst_mid_no_done", done_cnt - d0, 0);

        slave_bytes = '{8'h91, 8'h00, 8'h00, 8'h00};
        run_txn("post_rst", 1'b1, 7'h37, 8'd1, 8'h00, 2, 8'hEE, 8'h00, 8'h00, 8'h91, 1'b0, 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
